id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register of the RV32I pipeline, with load-use hazard detection.
//   Captures the main-control and ALU-control outputs plus operands, immediate and register
//   addresses for one instruction, and presents them to the EX stage one cycle later.
//   Inserts a one-cycle bubble when a load in EX feeds a register read by the instruction in ID.
//   Obeys the global stall input and the branch-resolution flush input.
// PARAMETERS
//   XLEN     32  datapath width (PC, operands, immediate)
//   RA_W     5   register address width
//   PERF_W   16  width of the saturating bubble counter
// PORTS
//   clk            in   1       pipeline clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   id_valid_i     in   1       ID holds a real instruction
//   id_pc_i        in   XLEN    PC of the ID instruction
//   id_rs1_data_i  in   XLEN    register-file read data, port 1
//   id_rs2_data_i  in   XLEN    register-file read data, port 2
//   id_imm_i       in   XLEN    sign-extended immediate
//   id_rs1_i       in   RA_W    rs1 address
//   id_rs2_i       in   RA_W    rs2 address
//   id_rd_i        in   RA_W    rd address
//   id_use_rs1_i   in   1       instruction reads rs1
//   id_use_rs2_i   in   1       instruction reads rs2
//   id_funct3_i    in   3       funct3 of the instruction
//   id_ctrl_i      in   14      {alu_src,mem_to_reg,reg_write,mem_read,mem_write,add_sel,link,
//                               lui,branch[1:0],alu_op[1:0]} from main control
//   id_alu_cnt_i   in   4       ALU control code
//   stall_ext_i    in   1       global stall: hold every register
//   flush_i        in   1       taken branch/jump resolved in EX: kill ID/EX
//   ex_valid_o     out  1       EX holds a real instruction
//   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o   out  XLEN   registered copies
//   ex_rs1_o, ex_rs2_o, ex_rd_o                       out  RA_W   registered copies
//   ex_funct3_o    out  3       registered copy
//   ex_ctrl_o      out  14      registered copy, sanitised (see below)
//   ex_alu_cnt_o   out  4       registered copy
//   load_use_stall_o out 1      combinational: upstream must hold PC and IF/ID this cycle
//   bubble_cnt_o   out  PERF_W  count of load-use bubbles inserted, saturating
// BEHAVIOUR
//   Reset (async, rst_n=0): all ex_* outputs and bubble_cnt_o are 0, ex_valid_o=0.
//     load_use_stall_o evaluates to 0 because ex_valid_o=0.
//   Hazard (combinational): hz = ex_valid_o & ex_ctrl_o.mem_read & (ex_rd_o!=0) & id_valid_i &
//     ((id_use_rs1_i & id_rs1_i==ex_rd_o) | (id_use_rs2_i & id_rs2_i==ex_rd_o)).
//   load_use_stall_o = hz & ~flush_i.
//   Per-edge priority, highest first:
//     1 flush_i: load a bubble (ex_valid_o=0, ex_ctrl_o=0, ex_alu_cnt_o=0; data fields don't-care,
//       driven 0). flush_i overrides stall_ext_i.
//     2 stall_ext_i: hold all registers and bubble_cnt_o.
//     3 hz: load a bubble; bubble_cnt_o += 1 unless it already holds all ones.
//     4 otherwise: capture the ID inputs; ex_valid_o = id_valid_i.
//   Sanitising on capture:
//     - id_valid_i=0 captures a bubble (all control 0).
//     - reg_write is stored as reg_write & (rd!=0), so x0 is never written.
//     - X or Z on a control input while id_valid_i=0 must not reach ex_ctrl_o.
//   Latency: 1 cycle ID->EX. A load-use pair costs exactly one bubble.
//     The cycle after the bubble, hz=0 (ex_valid_o=0), so the held instruction advances.
//   Simultaneous hz and stall_ext_i: the registers hold. load_use_stall_o remains 1. No count.
//   A back-to-back load followed by a dependent load behaves the same: one bubble per dependency.
// STRUCTURE
//   Shared rv32i_pkg/header holds:
//     - opcode constants
//     - ALUOp encodings 00/01/10/11
//     - ALUCnt codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRA 1000, XOR 1100,
//       SLL 1101, SRL 1110
//     - Branch encodings
//     - CTRL_W=14 and the bit indices of the ctrl bundle
//   Sub-module hazard_detect: purely combinational hz comparator, reused by forwarding checks.
// TESTING
//   Test 1: lw x5,0(x1) then add x6,x5,x2 in consecutive cycles.
//     Required: load_use_stall_o=1 for 1 cycle; ex_valid_o=0 that next cycle; the add reaches EX
//     one cycle later; bubble_cnt_o=1.
//   Test 2: lw x0 then a reader of x0.
//     Required: no stall, and ex_ctrl_o.reg_write=0 for the load.
//   Test 3: a dependent add is in ID while flush_i=1.
//     Required: next edge gives ex_valid_o=0, ex_ctrl_o=0; load_use_stall_o=0 during the flush.
//   Test 4: stall_ext_i=1 for 3 cycles during a hazard.
//     Required: registers and bubble_cnt_o are held; the bubble is inserted on the first
//     non-stalled edge.
//   Test 5: assert rst_n=0 asynchronously mid-stream with ex_valid_o=1.
//     Required: all outputs go to 0 immediately, without waiting for a clock edge.
//   Test 6: preload bubble_cnt_o to 16'hFFFF, then trigger a hazard.
//     Required: bubble_cnt_o stays at 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// RV32I shared definitions: opcodes, ALU/branch encodings and the layout of the 14-bit control bundle.
// Control bits [13:12] are spare and carried through unchanged on capture.
package id_ex_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRA = 4'b1000,
        ALU_XOR = 4'b1100,
        ALU_SLL = 4'b1101,
        ALU_SRL = 4'b1110
    } alucnt_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_JAL  = 2'b10,
        BR_JALR = 2'b11
    } branch_e;

    localparam int CTRL_W          = 14;
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_BRANCH_LSB = 2;
    localparam int CTRL_LUI        = 4;
    localparam int CTRL_LINK       = 5;
    localparam int CTRL_ADD_SEL    = 6;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 10;
    localparam int CTRL_ALU_SRC    = 11;

    // Bubble when not taken; never let a write to x0 through.
    function automatic logic [CTRL_W-1:0] sanitise_ctrl(input logic take,
                                                        input logic [CTRL_W-1:0] ctrl,
                                                        input logic rd_nz);
        logic [CTRL_W-1:0] c;
        c = take ? ctrl : '0;
        c[CTRL_REG_WRITE] = c[CTRL_REG_WRITE] & rd_nz;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose rd is read by the instruction in ID.
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            i_ex_valid,
    input  logic            i_ex_mem_read,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_id_valid,
    input  logic            i_use_rs1,
    input  logic [RA_W-1:0] i_rs1,
    input  logic            i_use_rs2,
    input  logic [RA_W-1:0] i_rs2,
    output logic            o_hz
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_use_rs1 & (i_rs1 == i_ex_rd);
    assign w_rs2_hit = i_use_rs2 & (i_rs2 == i_ex_rd);
    assign o_hz      = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0) & i_id_valid
                     & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, external stall, branch flush
// and a saturating count of inserted load-use bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [RA_W-1:0]   id_rs1_i,
    input  logic [RA_W-1:0]   id_rs2_i,
    input  logic [RA_W-1:0]   id_rd_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [2:0]        id_funct3_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [3:0]        id_alu_cnt_i,
    input  logic              stall_ext_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [RA_W-1:0]   ex_rs1_o,
    output logic [RA_W-1:0]   ex_rs2_o,
    output logic [RA_W-1:0]   ex_rd_o,
    output logic [2:0]        ex_funct3_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [3:0]        ex_alu_cnt_o,
    output logic              load_use_stall_o,
    output logic [PERF_W-1:0] bubble_cnt_o
);
    logic              r_valid;
    logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [RA_W-1:0]   r_rs1, r_rs2, r_rd;
    logic [2:0]        r_funct3;
    logic [CTRL_W-1:0] r_ctrl;
    logic [3:0]        r_alu_cnt;
    logic [PERF_W-1:0] r_bubble_cnt;

    logic w_hz;
    logic w_hold;
    logic w_take;
    logic w_count;

    hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
        .i_ex_rd       (r_rd),
        .i_id_valid    (id_valid_i),
        .i_use_rs1     (id_use_rs1_i),
        .i_rs1         (id_rs1_i),
        .i_use_rs2     (id_use_rs2_i),
        .i_rs2         (id_rs2_i),
        .o_hz          (w_hz)
    );

    // Flush beats stall; a hazard only inserts its bubble on an unstalled edge.
    assign w_hold  = stall_ext_i & ~flush_i;
    assign w_take  = ~flush_i & ~w_hz & id_valid_i;
    assign w_count = ~flush_i & ~stall_ext_i & w_hz & ~(&r_bubble_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_funct3     <= '0;
            r_ctrl       <= '0;
            r_alu_cnt    <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (!w_hold) begin
                r_valid    <= w_take;
                r_pc       <= w_take ? id_pc_i       : '0;
                r_rs1_data <= w_take ? id_rs1_data_i : '0;
                r_rs2_data <= w_take ? id_rs2_data_i : '0;
                r_imm      <= w_take ? id_imm_i      : '0;
                r_rs1      <= w_take ? id_rs1_i      : '0;
                r_rs2      <= w_take ? id_rs2_i      : '0;
                r_rd       <= w_take ? id_rd_i       : '0;
                r_funct3   <= w_take ? id_funct3_i   : '0;
                r_ctrl     <= sanitise_ctrl(w_take, id_ctrl_i, id_rd_i != '0);
                r_alu_cnt  <= w_take ? id_alu_cnt_i  : '0;
            end
            if (w_count) r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign load_use_stall_o = w_hz & ~flush_i;
    assign ex_valid_o       = r_valid;
    assign ex_pc_o          = r_pc;
    assign ex_rs1_data_o    = r_rs1_data;
    assign ex_rs2_data_o    = r_rs2_data;
    assign ex_imm_o         = r_imm;
    assign ex_rs1_o         = r_rs1;
    assign ex_rs2_o         = r_rs2;
    assign ex_rd_o          = r_rd;
    assign ex_funct3_o      = r_funct3;
    assign ex_ctrl_o        = r_ctrl;
    assign ex_alu_cnt_o     = r_alu_cnt;
    assign bubble_cnt_o     = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 3-bit counter exercises saturation.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i;
    logic [2:0]  id_funct3_i;
    logic [13:0] id_ctrl_i;
    logic [3:0]  id_alu_cnt_i;
    logic        stall_ext_i, flush_i;

    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [2:0]  ex_funct3_o;
    logic [13:0] ex_ctrl_o;
    logic [3:0]  ex_alu_cnt_o;
    logic        load_use_stall_o;
    logic [15:0] bubble_cnt_o;

    logic        s_valid, s_stall;
    logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_f3;
    logic [13:0] s_ctrl;
    logic [3:0]  s_acnt;
    logic [2:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // lw: alu_src|mem_to_reg|reg_write|mem_read ; add: reg_write|alu_op=10
    localparam logic [13:0] C_LW     = 14'h0F00;
    localparam logic [13:0] C_LW_X0  = 14'h0D00;
    localparam logic [13:0] C_ADD    = 14'h0202;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_funct3_i(id_funct3_i),
        .id_ctrl_i(id_ctrl_i), .id_alu_cnt_i(id_alu_cnt_i), .stall_ext_i(stall_ext_i),
        .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct3_o(ex_funct3_o),
        .ex_ctrl_o(ex_ctrl_o), .ex_alu_cnt_o(ex_alu_cnt_o),
        .load_use_stall_o(load_use_stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.PERF_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_funct3_i(id_funct3_i),
        .id_ctrl_i(id_ctrl_i), .id_alu_cnt_i(id_alu_cnt_i), .stall_ext_i(stall_ext_i),
        .flush_i(flush_i), .ex_valid_o(s_valid), .ex_pc_o(s_pc),
        .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d), .ex_imm_o(s_imm),
        .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd), .ex_funct3_o(s_f3),
        .ex_ctrl_o(s_ctrl), .ex_alu_cnt_o(s_acnt),
        .load_use_stall_o(s_stall), .bubble_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic [13:0] ctrl, input logic [3:0] acnt);
        id_valid_i    = v;
        id_pc_i       = pc;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_rd_i       = rd;
        id_use_rs1_i  = u1;
        id_use_rs2_i  = u2;
        id_ctrl_i     = ctrl;
        id_alu_cnt_i  = acnt;
        id_rs1_data_i = 32'hA000_0000 | pc;
        id_rs2_data_i = 32'hB000_0000 | pc;
        id_imm_i      = 32'h0000_0010;
        id_funct3_i   = (ctrl == C_ADD) ? 3'b000 : 3'b010;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall_ext_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 14'h0, 4'h0);
        #3;
        chk("rst_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_ctrl",  32'(ex_ctrl_o),  32'd0);
        chk("rst_cnt",   32'(bubble_cnt_o), 32'd0);
        chk("rst_stall", 32'(load_use_stall_o), 32'd0);
        #10 rst_n = 1'b1;

        // Test 1: lw x5,0(x1) ; add x6,x5,x2
        drive(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 4'b0010);
        tick();
        chk("t1_lw_valid", 32'(ex_valid_o), 32'd1);
        chk("t1_lw_ctrl",  32'(ex_ctrl_o),  32'(C_LW));
        chk("t1_lw_rd",    32'(ex_rd_o),    32'd5);
        chk("t1_lw_pc",    ex_pc_o,         32'h100);
        drive(1'b1, 32'h104, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD, 4'b0010);
        chk("t1_stall", 32'(load_use_stall_o), 32'd1);
        tick();
        chk("t1_bub_valid", 32'(ex_valid_o), 32'd0);
        chk("t1_bub_ctrl",  32'(ex_ctrl_o),  32'd0);
        chk("t1_cnt",       32'(bubble_cnt_o), 32'd1);
        chk("t1_stall_off", 32'(load_use_stall_o), 32'd0);
        tick();
        chk("t1_add_valid", 32'(ex_valid_o), 32'd1);
        chk("t1_add_pc",    ex_pc_o,         32'h104);
        chk("t1_add_rd",    32'(ex_rd_o),    32'd6);
        chk("t1_add_ctrl",  32'(ex_ctrl_o),  32'(C_ADD));
        chk("t1_add_rs1d",  ex_rs1_data_o,   32'hA000_0104);
        chk("t1_add_rs2d",  ex_rs2_data_o,   32'hB000_0104);
        chk("t1_add_imm",   ex_imm_o,        32'h10);
        chk("t1_add_rs2",   32'(ex_rs2_o),   32'd2);

        // Test 2: lw x0 ; add x7,x0,x0
        drive(1'b1, 32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 4'b0010);
        tick();
        chk("t2_lw_ctrl",  32'(ex_ctrl_o), 32'(C_LW_X0));
        chk("t2_lw_f3",    32'(ex_funct3_o), 32'd2);
        drive(1'b1, 32'h204, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, C_ADD, 4'b0010);
        chk("t2_stall", 32'(load_use_stall_o), 32'd0);
        tick();
        chk("t2_add_valid", 32'(ex_valid_o), 32'd1);
        chk("t2_add_pc",    ex_pc_o,         32'h204);
        chk("t2_cnt",       32'(bubble_cnt_o), 32'd1);

        // Test 3: dependent add under flush
        drive(1'b1, 32'h300, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, C_LW, 4'b0010);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h304, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, C_ADD, 4'b0010);
        chk("t3_stall", 32'(load_use_stall_o), 32'd0);
        tick();
        chk("t3_valid", 32'(ex_valid_o), 32'd0);
        chk("t3_ctrl",  32'(ex_ctrl_o),  32'd0);
        chk("t3_acnt",  32'(ex_alu_cnt_o), 32'd0);
        chk("t3_cnt",   32'(bubble_cnt_o), 32'd1);
        flush_i = 1'b0;

        // Test 4: external stall during a hazard
        drive(1'b1, 32'h400, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, C_LW, 4'b0010);
        tick();
        stall_ext_i = 1'b1;
        drive(1'b1, 32'h404, 5'd3, 5'd10, 5'd11, 1'b1, 1'b1, C_ADD, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall", 32'(load_use_stall_o), 32'd1);
            tick();
            chk("t4_hold_valid", 32'(ex_valid_o), 32'd1);
            chk("t4_hold_pc",    ex_pc_o,         32'h400);
            chk("t4_hold_cnt",   32'(bubble_cnt_o), 32'd1);
        end
        stall_ext_i = 1'b0;
        #1;
        chk("t4_stall_rel", 32'(load_use_stall_o), 32'd1);
        tick();
        chk("t4_bub_valid", 32'(ex_valid_o), 32'd0);
        chk("t4_cnt",       32'(bubble_cnt_o), 32'd2);
        tick();
        chk("t4_add_pc",    ex_pc_o, 32'h404);

        // Back-to-back dependent loads: lw x12 ; lw x13,0(x12) ; add x14,x13
        drive(1'b1, 32'h500, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, C_LW, 4'b0010);
        tick();
        drive(1'b1, 32'h504, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, C_LW, 4'b0010);
        tick();
        chk("b2b_bub1", 32'(ex_valid_o), 32'd0);
        tick();
        chk("b2b_lw2_pc", ex_pc_o, 32'h504);
        drive(1'b1, 32'h508, 5'd4, 5'd13, 5'd14, 1'b1, 1'b1, C_ADD, 4'b0010);
        tick();
        chk("b2b_bub2", 32'(ex_valid_o), 32'd0);
        chk("b2b_cnt",  32'(bubble_cnt_o), 32'd4);
        tick();
        chk("b2b_add_pc", ex_pc_o, 32'h508);

        // Invalid ID with unknown control must capture a clean bubble
        drive(1'b0, 32'h600, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 14'bx, 4'bx);
        tick();
        chk("inv_valid", 32'(ex_valid_o),   32'd0);
        chk("inv_ctrl",  32'(ex_ctrl_o),    32'd0);
        chk("inv_acnt",  32'(ex_alu_cnt_o), 32'd0);

        // Test 6: saturation on the 3-bit counter instance (starts at 4)
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h700, 5'd1, 5'd0, 5'd15, 1'b1, 1'b0, C_LW, 4'b0010);
            tick();
            drive(1'b1, 32'h704, 5'd15, 5'd0, 5'd16, 1'b1, 1'b0, C_ADD, 4'b0010);
            tick();
            chk("sat_small", 32'(s_cnt), (i < 3) ? 32'(5 + i) : 32'd7);
            chk("sat_main",  32'(bubble_cnt_o), 32'(5 + i));
            tick();
        end

        // Test 5: asynchronous reset mid-stream
        chk("t5_pre_valid", 32'(ex_valid_o), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(ex_valid_o),   32'd0);
        chk("t5_pc",    ex_pc_o,           32'd0);
        chk("t5_ctrl",  32'(ex_ctrl_o),    32'd0);
        chk("t5_rd",    32'(ex_rd_o),      32'd0);
        chk("t5_cnt",   32'(bubble_cnt_o), 32'd0);
        chk("t5_scnt",  32'(s_cnt),        32'd0);
        chk("t5_stall", 32'(load_use_stall_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
